// File: rtl/baudot_rx_sequencer.sv
// Baudot receive sequencer: synchronizes the serial line, frames 5-bit codes,
// tracks LTRS/FIGS shift state and hands printable codes downstream.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   baudot_in         : async serial line, idle/mark = 1
//   code_out/figs_out : held code (bit 0 first received) and its shift state
//   code_valid        : code_out/figs_out hold a character
//   code_ready        : downstream accepts the character
//   baudot_ready      : registered "idle with nothing pending"
//   framing_err       : one-cycle pulse on a bad stop bit
//   overrun           : one-cycle pulse when a character is dropped
module baudot_rx_sequencer #(
    parameter int CLKS_PER_BIT     = 22,
    parameter bit UNSHIFT_ON_SPACE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baudot_in,
    output logic [4:0] code_out,
    output logic       figs_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       baudot_ready,
    output logic       framing_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [4:0] LTRS  = 5'b11111;
    localparam logic [4:0] FIGS  = 5'b11011;
    localparam logic [4:0] SPACE = 5'b00100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_MARK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_q, rx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    shreg_q, shreg_d;
    logic          figs_q, figs_d;
    logic [4:0]    code_q, code_d;
    logic          figs_out_q, figs_out_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          bready_q, bready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rx_q       <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            figs_q     <= 1'b0;
            code_q     <= '0;
            figs_out_q <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            figs_q     <= figs_d;
            code_q     <= code_d;
            figs_out_q <= figs_out_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            bready_q   <= bready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync1_d    = baudot_in;
        rx_d       = sync1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        figs_d     = figs_q;
        code_d     = code_q;
        figs_out_d = figs_out_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;

        if (valid_q && code_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A high line at mid start bit is a glitch.
                    state_d = rx_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    // Shift right so the first bit lands in bit 0.
                    shreg_d = {rx_q, shreg_q[4:1]};
                    if (idx_q == 3'd4) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!rx_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_MARK;
                    end else begin
                        state_d = S_IDLE;
                        if (shreg_q == LTRS) begin
                            figs_d = 1'b0;
                        end else if (shreg_q == FIGS) begin
                            figs_d = 1'b1;
                        end else begin
                            // Overrun is judged on the held flag, even if
                            // it is being accepted in this same cycle.
                            if (valid_q) begin
                                ovr_d = 1'b1;
                            end else begin
                                code_d     = shreg_q;
                                figs_out_d = figs_q;
                                valid_d    = 1'b1;
                            end
                            if (UNSHIFT_ON_SPACE && shreg_q == SPACE) begin
                                figs_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_MARK: begin
                if (rx_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bready_d = (state_d == S_IDLE) && !valid_d;
    end

    assign code_out     = code_q;
    assign figs_out     = figs_out_q;
    assign code_valid   = valid_q;
    assign framing_err  = ferr_q;
    assign overrun      = ovr_q;
    assign baudot_ready = bready_q;

endmodule

// File: tb/tb_baudot_rx_sequencer.sv
// Bench for baudot_rx_sequencer: two instances (space-unshift off/on) share
// one serial line; an event-driven model predicts every output cycle.
module tb_baudot_rx_sequencer;

    localparam int C  = 22;
    localparam int H  = C / 2;
    localparam int EV = 2 + H + 6 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baudot_in = 1'b1;
    logic code_ready = 1'b0;

    logic [1:0][4:0] d_code;
    logic [1:0]      d_figs, d_valid, d_br, d_ferr, d_ovr;

    baudot_rx_sequencer #(.CLKS_PER_BIT(C), .UNSHIFT_ON_SPACE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .baudot_in(baudot_in),
        .code_out(d_code[0]), .figs_out(d_figs[0]), .code_valid(d_valid[0]),
        .code_ready(code_ready), .baudot_ready(d_br[0]),
        .framing_err(d_ferr[0]), .overrun(d_ovr[0])
    );

    baudot_rx_sequencer #(.CLKS_PER_BIT(C), .UNSHIFT_ON_SPACE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .baudot_in(baudot_in),
        .code_out(d_code[1]), .figs_out(d_figs[1]), .code_valid(d_valid[1]),
        .code_ready(code_ready), .baudot_ready(d_br[1]),
        .framing_err(d_ferr[1]), .overrun(d_ovr[1])
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int         t;
        logic [4:0] code;
        bit         good;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    bit  chk_en = 0;
    bit  rnd_rdy = 0;

    bit         m_valid[2];
    bit         m_figs[2];
    bit         m_ofigs[2];
    bit         m_ferr[2];
    bit         m_ovr[2];
    logic [4:0] m_code[2];

    int         rises[2];
    int         ovrs[2];
    bit         pv[2];
    bit         last_figs[2];
    logic [4:0] last_code[2];

    // Reference model: applies each frame's outcome at its stop-sample edge.
    always @(posedge clk) begin
        bit  old[2];
        ev_t e;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_ferr[i] = 0;
            m_ovr[i]  = 0;
        end
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0;
                m_figs[i]  = 0;
                m_ofigs[i] = 0;
                m_code[i]  = '0;
            end
            evq.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                old[i] = m_valid[i];
                if (m_valid[i] && code_ready) m_valid[i] = 0;
            end
            if (evq.size() > 0 && evq[0].t == cyc) begin
                e = evq.pop_front();
                for (int i = 0; i < 2; i++) begin
                    if (!e.good) m_ferr[i] = 1;
                    else if (e.code == 5'd31) m_figs[i] = 0;
                    else if (e.code == 5'd27) m_figs[i] = 1;
                    else begin
                        if (old[i]) m_ovr[i] = 1;
                        else begin
                            m_valid[i] = 1;
                            m_code[i]  = e.code;
                            m_ofigs[i] = m_figs[i];
                        end
                        if (i == 1 && e.code == 5'd4) m_figs[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("valid%0d", i), d_valid[i], m_valid[i]);
                check($sformatf("ferr%0d", i), d_ferr[i], m_ferr[i]);
                check($sformatf("ovr%0d", i), d_ovr[i], m_ovr[i]);
                if (m_valid[i]) begin
                    check($sformatf("code%0d", i), d_code[i], m_code[i]);
                    check($sformatf("figs%0d", i), d_figs[i], m_ofigs[i]);
                end
                if (d_valid[i] && !pv[i]) begin
                    rises[i]++;
                    last_figs[i] = d_figs[i];
                    last_code[i] = d_code[i];
                end
                if (d_ovr[i] === 1'b1) ovrs[i]++;
                pv[i] = d_valid[i];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rnd_rdy) code_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            baudot_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [4:0] code, input bit stop);
        ev_t  e;
        logic lvl;
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < C; k++) begin
                tick();
                if (k == 0) begin
                    if (j == 0) lvl = 1'b0;
                    else if (j == 6) lvl = stop;
                    else lvl = code[j-1];
                    baudot_in = lvl;
                    if (j == 0) begin
                        e.t    = cyc + 1 + EV;
                        e.code = code;
                        e.good = stop;
                        evq.push_back(e);
                    end
                end
                if (j == 3 && k == H) check("br_mid", d_br[0], 1'b0);
            end
        end
    endtask

    initial begin
        int r0, o0;
        logic [4:0] rc;
        bit good;

        // reset
        rst = 1'b1;
        tick();
        chk_en = 1;
        check("rst_br", d_br[0], 1'b0);
        check("rst_code", d_code[0], 5'd0);
        check("rst_figs", d_figs[0], 1'b0);
        tick();
        tick();
        check("rst_br2", d_br[1], 1'b0);
        rst = 1'b0;
        tick();
        check("br_after_rst", d_br[0], 1'b1);
        check("br_after_rst1", d_br[1], 1'b1);
        idle(500);

        // letter frame and handshake
        code_ready = 1'b0;
        send_frame(5'b00011, 1'b1);
        check("letter_code", d_code[0], 5'b00011);
        check("br_hold", d_br[0], 1'b0);
        idle(20);
        check("letter_held", d_valid[0], 1'b1);
        code_ready = 1'b1;
        tick();
        check("hs_drop", d_valid[0], 1'b0);
        idle(5);

        // shift tracking
        r0 = rises[0];
        send_frame(5'b11011, 1'b1);
        send_frame(5'b00011, 1'b1);
        check("figs_emit", last_figs[0], 1'b1);
        send_frame(5'b11111, 1'b1);
        send_frame(5'b00011, 1'b1);
        check("ltrs_emit", last_figs[0], 1'b0);
        idle(10);
        check("shift_nvalid", rises[0] - r0, 2);

        // glitch
        tick();
        baudot_in = 1'b0;
        repeat (5) tick();
        baudot_in = 1'b1;
        idle(60);
        check("glitch_br", d_br[0], 1'b1);

        // framing error then line held low
        send_frame(5'b01010, 1'b0);
        repeat (100) tick();
        check("wait_mark_br", d_br[0], 1'b0);
        idle(10);
        check("mark_br", d_br[0], 1'b1);

        // overrun
        code_ready = 1'b0;
        o0 = ovrs[0];
        send_frame(5'b00001, 1'b1);
        send_frame(5'b00010, 1'b1);
        idle(5);
        check("ovr_code", d_code[0], 5'b00001);
        check("ovr_count", ovrs[0] - o0, 1);
        code_ready = 1'b1;
        idle(5);

        // unshift on space
        send_frame(5'b11011, 1'b1);
        send_frame(5'b00100, 1'b1);
        check("space_figs1", last_figs[1], 1'b1);
        send_frame(5'b00011, 1'b1);
        check("unshift_figs1", last_figs[1], 1'b0);
        check("keep_figs0", last_figs[0], 1'b1);
        idle(5);

        // mid-frame reset during data bit 2
        rc = 5'b00011;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < C; k++) begin
                if (!(j == 3 && k > H)) begin
                    tick();
                    if (k == 0) baudot_in = (j == 0) ? 1'b0 : rc[j-1];
                end
            end
        end
        tick();
        rst = 1'b1;
        baudot_in = 1'b1;
        tick();
        rst = 1'b0;
        idle(30);
        send_frame(5'b00011, 1'b1);
        check("rst_clean_code", last_code[0], 5'b00011);
        check("rst_clean_figs", last_figs[1], 1'b0);
        idle(5);

        // randomized frames with random downstream readiness
        rnd_rdy = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                rc = ($urandom_range(0, 1) != 0) ? 5'b11011 : 5'b11111;
            else if ($urandom_range(0, 7) == 0)
                rc = 5'b00100;
            else
                rc = 5'($urandom_range(0, 31));
            good = ($urandom_range(0, 9) != 0);
            send_frame(rc, good);
            if (!good) idle(4 + $urandom_range(0, 20));
            else if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 30));
        end
        rnd_rdy = 0;
        code_ready = 1'b1;
        idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/baudot_rx_sequencer.md
# baudot_rx_sequencer

Receive-side controller for the Baudot-to-ASCII converter. It sequences the incoming 5-bit Baudot line and tracks the LTRS/FIGS shift state. It hands each printable code, tagged with its shift, to the ASCII encoding stage over a valid/ready handshake, and drives `baudot_ready` back toward the sender. Shift characters are consumed here and never forwarded.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 22: clock cycles per Baudot bit (about 45.45 baud at CLOCK_RATE=1000). Minimum 4.
- `UNSHIFT_ON_SPACE`, default 0: when 1, a received SPACE (5'b00100) forces the shift state to letters after the SPACE is emitted.

Ports:

- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `baudot_in`, input, 1: asynchronous serial line. Idle/mark = 1.
- `code_out`, output, 5: received Baudot code. First-received bit is bit 0.
- `figs_out`, output, 1: shift state for `code_out` (0 = letters, 1 = figures).
- `code_valid`, output, 1: `code_out`/`figs_out` hold a character.
- `code_ready`, input, 1: downstream accepts the character.
- `baudot_ready`, output, 1: block is idle with no pending character.
- `framing_err`, output, 1: one-cycle pulse when a bad stop bit is seen.
- `overrun`, output, 1: one-cycle pulse when a character is dropped.

## Operation

- **Input synchronizer.** `baudot_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `rx`.
- **States:** IDLE, START, DATA, STOP, WAIT_MARK. A single bit counter runs from 0 to `CLKS_PER_BIT`-1; a bit index runs 0..4.
- **IDLE.** `rx`=0 moves to START with the counter cleared.
- **START.** After H = `CLKS_PER_BIT`/2 (integer division) cycles, sample `rx`.
  - If `rx`=1, treat it as a glitch: return to IDLE with no flag.
  - If `rx`=0, go to DATA.
- **DATA.** Every `CLKS_PER_BIT` cycles, sample `rx` into shift-register bit[index]. After the 5th sample, go to STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, sample `rx`.
  - If `rx`=0: pulse `framing_err`, discard the code, go to WAIT_MARK.
  - If `rx`=1: process the code (below) and go to IDLE.
- **WAIT_MARK.** Stay until `rx`=1, then go to IDLE.
- **Processing a received code:**
  - 5'b11111 (LTRS): figs←0. Nothing emitted.
  - 5'b11011 (FIGS): figs←1. Nothing emitted.
  - Any other code with `code_valid`=0: load `code_out`, set `figs_out`←current figs, set `code_valid`←1.
  - Any other code with `code_valid`=1: pulse `overrun`. The new code is dropped and the held code is unchanged.
  - SPACE with `UNSHIFT_ON_SPACE`=1: emitted with the current figs (or overrun), then figs←0.
  - A shift code never causes an overrun.
- **Handshake.**
  - `code_valid` stays high until a cycle in which `code_valid`&`code_ready`=1. It is low on the following cycle.
  - `code_out` and `figs_out` are stable while `code_valid` is high.
  - `code_ready` is ignored while `code_valid`=0.
  - Reception continues independently of the handshake.
- **`baudot_ready`** is registered: state==IDLE and `code_valid`==0, delayed one cycle.
- **Reset** (any state, including mid-frame):
  - state IDLE, figs=0, counters 0, synchronizer flops 1.
  - `code_out`=0, `figs_out`=0, `code_valid`=0, `framing_err`=0, `overrun`=0, `baudot_ready`=0.
  - A partial frame is discarded.

## Timing

- Cycle 0 is the first rising edge at which `baudot_in`=0 is registered. `rx` is 0 at cycle 2.
- Sample points:
  - START sample at cycle 2+H.
  - Data bit k sampled at cycle 2+H+(k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at cycle 2+H+6·`CLKS_PER_BIT`.
- `code_valid` rises at cycle L = 3+H+6·`CLKS_PER_BIT` (146 for the default 22). `framing_err` and `overrun` pulse in that same cycle.
- `baudot_ready` is 1 from the second cycle after `rst` falls with the line idle. It is 0 from cycle 3 of a frame until IDLE is reached with `code_valid`=0, plus 1 cycle.
- A new start edge is accepted on the cycle after the STOP→IDLE return, so back-to-back frames with only 1 stop bit decode correctly.

## Test plan

- **Reset.** Hold `rst` high for 3 cycles with the line high, then release → all outputs 0 during reset; `baudot_ready`=1 from the 2nd cycle after release; no `code_valid` for 500 cycles.
- **Letter frame and handshake.** Send 5'b00011 (bits 1,1,0,0,0), `code_ready`=0 → `code_valid` rises at cycle 146 with `code_out`=5'b00011, `figs_out`=0, held stable for 20 cycles. Raise `code_ready` → `code_valid`=0 the next cycle.
- **Shift tracking.** Send FIGS, 5'b00011, LTRS, 5'b00011 with `code_ready`=1 → exactly two valids: (00011, figs 1), then (00011, figs 0). No valid for the shift frames.
- **Glitch and framing error.**
  - A 5-cycle low pulse → no state change and no flags.
  - A frame with stop bit 0 → `framing_err` is a single-cycle pulse at cycle 146, with no valid.
  - Line held low for 100 more cycles → no new frame until the line returns high.
- **Overrun.** Two frames, 5'b00001 then 5'b00010, with `code_ready`=0 → one `overrun` pulse at the second frame's cycle 146; `code_out` stays 5'b00001.
- **Unshift and mid-frame reset.**
  - With `UNSHIFT_ON_SPACE`=1, send FIGS, SPACE, 5'b00011 → SPACE emitted with `figs_out`=1, then 00011 with `figs_out`=0.
  - Assert `rst` for 1 cycle during data bit 2 → next frame decodes cleanly with figs=0.
